dcache_mshr_ctrl: RTL and testbench
===================================

# dcache_mshr_ctrl

Miss-status holding register controller for the data cache, sized by `DCACHE_MSHR_SIZE`. It sits between the DCache miss path and the memory port. It allocates one entry per outstanding line miss and merges secondary misses to the same line. It issues line reads to memory under round-robin arbitration and routes tagged refills back into the cache array.

## Interface
- `MSHR_SIZE`, 4, number of entries; must be ≥2.
- `PLEN`, 32, physical address width.
- `LINE_WIDTH`, 256, cache line width in bits.
- `OFFSET_W`, `$clog2(LINE_WIDTH/8)`, line offset width. Derived; do not override.
- `ID_W`, `$clog2(MSHR_SIZE)`, entry id width. Derived.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous, active-low reset.
- `miss_valid_i`  in  1  primary miss request.
- `miss_ready_o`  out  1  miss accepted this cycle.
- `miss_line_i`  in  PLEN-OFFSET_W  line address of the miss.
- `miss_id_o`  out  ID_W  entry that owns the line. Valid on miss handshake.
- `miss_merged_o`  out  1  miss merged into an existing entry. Valid on miss handshake.
- `mem_req_valid_o`  out  1  line read request to memory.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_req_line_o`  out  PLEN-OFFSET_W  line address of the request.
- `mem_req_id_o`  out  ID_W  tag of the request.
- `mem_rsp_valid_i`  in  1  refill data from memory.
- `mem_rsp_ready_o`  out  1  refill consumed.
- `mem_rsp_id_i`  in  ID_W  tag of the refill.
- `mem_rsp_data_i`  in  LINE_WIDTH  refill line data.
- `fill_valid_o`  out  1  write the line into the cache array.
- `fill_ready_i`  in  1  cache array accepts the fill.
- `fill_line_o`  out  PLEN-OFFSET_W  line address of the fill.
- `fill_data_o`  out  LINE_WIDTH  line data of the fill.
- `fill_id_o`  out  ID_W  entry being retired.
- `flush_i`  in  1  pipeline flush.

## Operation
- Each entry holds a state, a line address, and a drop bit. States:
  - FREE: unused.
  - PEND: allocated, not yet issued.
  - WAIT: issued, awaiting refill.
- Transitions:
  - FREE→PEND on allocation.
  - PEND→WAIT on a `mem_req` handshake.
  - WAIT→FREE on a `mem_rsp` handshake.
  - PEND→FREE on `flush_i`.
- Lookup: `miss_line_i` is compared against every PEND/WAIT entry.
  - Match: accept with `miss_id_o` = the matching entry and `miss_merged_o`=1. No new entry is allocated.
  - No match: allocate the lowest-index FREE entry, with `miss_merged_o`=0.
  - No FREE entry and no match: `miss_ready_o`=0.
- Retire conflict: a miss matching an entry that retires in the same cycle gets `miss_ready_o`=0 for that cycle.
- Freed entries become allocatable on the next cycle, not the cycle they free.
- Issue arbitration is round-robin over PEND entries.
  - The pointer advances to grant+1 (mod MSHR_SIZE) on each `mem_req` handshake.
  - `mem_req_*` must stay stable while valid and not ready, unless `flush_i` kills the entry.
- Refill path:
  - For a live WAIT entry, `fill_valid_o` = `mem_rsp_valid_i`, and `fill_data_o`/`fill_line_o` pass straight through. `mem_rsp_ready_o` = `fill_ready_i`.
  - For a WAIT entry with the drop bit set, `mem_rsp_ready_o`=1 and `fill_valid_o`=0.
- Flush: `flush_i` frees all PEND entries and sets the drop bit on all WAIT entries. A miss presented in the same cycle as `flush_i` is not accepted.
- A refill whose id points to a FREE or PEND entry is consumed and ignored. The bench flags it with an assertion.

## Timing
- Reset (`rst_ni` low at a rising edge):
  - All entries go FREE with drop bits cleared, and the round-robin pointer goes to 0.
  - `mem_req_valid_o`=0, `fill_valid_o`=0, and `miss_ready_o`=0 while reset is held.
  - All outputs are 0 in the reset cycle.
- Reset mid-operation discards every entry. Refills still in flight after reset are treated as tags to FREE entries.
- A miss accepted at cycle N makes its entry PEND at N+1. The earliest `mem_req_valid_o` is therefore N+1, since all outputs are driven from registered state.
- `mem_req` handshake at cycle M → entry is WAIT at M+1.
- Refill handshake at cycle R → `fill_valid_o` asserts at R (combinational pass-through), and the entry is FREE at R+1.
- When the refill and the allocation target different entries, a refill, a miss allocation, and a memory issue can all complete in the same cycle.

## Configuration
- `DCACHE_MSHR_MERGE_EN` defined: secondary misses merge as described under Operation.
- Undefined: a miss matching a PEND/WAIT entry gets `miss_ready_o`=0 until that entry frees. `miss_merged_o` is tied to 0.

## Test plan
- Basic miss: after reset, miss to line 0x100 → `miss_id_o`=0, `mem_req` with line 0x100 and id 0 at the next cycle. Refill id 0 → `fill_valid_o` with line 0x100, and entry 0 is FREE one cycle later.
- Capacity: 5 misses to distinct lines with MSHR_SIZE=4 → ids 0,1,2,3 granted and the 5th stalls. A refill of id 2 lets the 5th allocate id 2 one cycle later.
- Merge: miss 0x200 then miss 0x200 → second miss gets `miss_merged_o`=1 with the same id, and exactly one `mem_req` is issued. With the macro undefined, the second miss stalls until the refill.
- Round-robin: entries 0–3 all PEND with `mem_req_ready_i` held low for 3 cycles, then high → grants in order 0,1,2,3. Each `mem_req_*` is stable while stalled.
- Flush: entries 0,1 WAIT and 2,3 PEND, then `flush_i` → 2,3 FREE at the next cycle. Refills for 0,1 give `mem_rsp_ready_o`=1 and `fill_valid_o`=0 with `fill_ready_i`=0.
- Backpressure and reset: refill with `fill_ready_i`=0 → `mem_rsp_ready_o`=0 and the entry stays WAIT. Asserting `rst_ni`=0 for 1 cycle → all outputs 0, and the next miss allocates id 0.

Source files
------------

// File: rtl/dcache_mshr_ctrl.sv
// dcache_mshr_ctrl: miss-status holding registers between the DCache miss path and memory.
// One entry per outstanding line miss; secondary misses to a live line merge into its entry
// when DCACHE_MSHR_MERGE_EN is defined, otherwise they stall until that entry frees.
// Line reads are issued round-robin over pending entries; tagged refills pass straight
// through to the cache array fill port.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   miss_*                        primary miss request (valid/ready), owning id, merged flag
//   mem_req_*                     line read request to memory (valid/ready, line, tag)
//   mem_rsp_*                     tagged refill from memory (valid/ready, tag, data)
//   fill_*                        line write into the cache array (valid/ready, line, data, id)
//   flush_i                       frees pending entries, marks issued entries to drop refills
module dcache_mshr_ctrl #(
  parameter int unsigned MSHR_SIZE  = 4,
  parameter int unsigned PLEN       = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned OFFSET_W   = $clog2(LINE_WIDTH / 8),
  parameter int unsigned ID_W       = $clog2(MSHR_SIZE)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     miss_valid_i,
  output logic                     miss_ready_o,
  input  logic [PLEN-OFFSET_W-1:0] miss_line_i,
  output logic [ID_W-1:0]          miss_id_o,
  output logic                     miss_merged_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [PLEN-OFFSET_W-1:0] mem_req_line_o,
  output logic [ID_W-1:0]          mem_req_id_o,
  input  logic                     mem_rsp_valid_i,
  output logic                     mem_rsp_ready_o,
  input  logic [ID_W-1:0]          mem_rsp_id_i,
  input  logic [LINE_WIDTH-1:0]    mem_rsp_data_i,
  output logic                     fill_valid_o,
  input  logic                     fill_ready_i,
  output logic [PLEN-OFFSET_W-1:0] fill_line_o,
  output logic [LINE_WIDTH-1:0]    fill_data_o,
  output logic [ID_W-1:0]          fill_id_o,
  input  logic                     flush_i
);

  localparam int unsigned LineW = PLEN - OFFSET_W;

  typedef enum logic [1:0] {StFree, StPend, StWait} entry_st_e;

  entry_st_e              st_q   [MSHR_SIZE];
  entry_st_e              st_d   [MSHR_SIZE];
  logic [LineW-1:0]       line_q [MSHR_SIZE];
  logic [LineW-1:0]       line_d [MSHR_SIZE];
  logic [MSHR_SIZE-1:0]   drop_q, drop_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  // Remembers a stalled grant so a newly pending entry cannot steal the request mid-stall.
  logic                   lock_q, lock_d;
  logic [ID_W-1:0]        lock_id_q, lock_id_d;

  logic            hit, free_any, can_accept, merged;
  logic [ID_W-1:0] hit_id, free_id, miss_id;
  logic            rr_any, hold;
  logic [ID_W-1:0] rr_gnt, cand, gnt_id;
  logic            rsp_wait, rsp_live, retire, miss_hs, req_hs;

  // Line lookup over live entries and lowest-index free entry.
  always_comb begin
    hit      = 1'b0;
    hit_id   = '0;
    free_any = 1'b0;
    free_id  = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      if (st_q[i] != StFree && line_q[i] == miss_line_i) begin
        hit    = 1'b1;
        hit_id = ID_W'(i);
      end
    end
    for (int i = int'(MSHR_SIZE) - 1; i >= 0; i--) begin
      if (st_q[i] == StFree) begin
        free_any = 1'b1;
        free_id  = ID_W'(i);
      end
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    rr_any = 1'b0;
    rr_gnt = '0;
    cand   = '0;
    for (int k = 0; k < MSHR_SIZE; k++) begin
      cand = ID_W'((int'(rr_q) + k) % int'(MSHR_SIZE));
      if (!rr_any && st_q[cand] == StPend) begin
        rr_any = 1'b1;
        rr_gnt = cand;
      end
    end
    hold   = lock_q && (st_q[lock_id_q] == StPend);
    gnt_id = hold ? lock_id_q : rr_gnt;
  end

  // Refill routing and miss acceptance.
  always_comb begin
    rsp_wait = (st_q[mem_rsp_id_i] == StWait);
    rsp_live = rsp_wait && !drop_q[mem_rsp_id_i];
    miss_id  = hit ? hit_id : free_id;
`ifdef DCACHE_MSHR_MERGE_EN
    // A merge into an entry retiring this cycle would be lost, so stall it one cycle.
    can_accept = hit ? !(retire && mem_rsp_id_i == hit_id) : free_any;
    merged     = hit;
`else
    can_accept = !hit && free_any;
    merged     = 1'b0;
`endif

    miss_ready_o    = rst_ni && miss_valid_i && !flush_i && can_accept;
    miss_id_o       = rst_ni ? miss_id : '0;
    miss_merged_o   = rst_ni && merged;
    mem_req_valid_o = rst_ni && rr_any;
    mem_req_line_o  = rst_ni ? line_q[gnt_id] : '0;
    mem_req_id_o    = rst_ni ? gnt_id : '0;
    // Dropped and stale refills are swallowed regardless of fill backpressure.
    mem_rsp_ready_o = rst_ni && (rsp_live ? fill_ready_i : 1'b1);
    fill_valid_o    = rst_ni && rsp_live && mem_rsp_valid_i;
    fill_line_o     = rst_ni ? line_q[mem_rsp_id_i] : '0;
    fill_data_o     = rst_ni ? mem_rsp_data_i : '0;
    fill_id_o       = rst_ni ? mem_rsp_id_i : '0;
  end

  assign retire  = mem_rsp_valid_i && mem_rsp_ready_o && rsp_wait;
  assign miss_hs = miss_valid_i && miss_ready_o;
  assign req_hs  = mem_req_valid_o && mem_req_ready_i;

  always_comb begin
    st_d      = st_q;
    line_d    = line_q;
    drop_d    = drop_q;
    rr_d      = rr_q;
    lock_d    = mem_req_valid_o && !mem_req_ready_i;
    lock_id_d = gnt_id;
    if (flush_i) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        if (st_q[i] == StPend) st_d[i] = StFree;
        if (st_q[i] == StWait) drop_d[i] = 1'b1;
      end
    end
    // An entry issued in the flush cycle is already in flight, so it waits with drop set.
    if (req_hs) begin
      st_d[gnt_id]   = StWait;
      drop_d[gnt_id] = flush_i;
      rr_d           = ID_W'((int'(gnt_id) + 1) % int'(MSHR_SIZE));
    end
    if (retire) begin
      st_d[mem_rsp_id_i]   = StFree;
      drop_d[mem_rsp_id_i] = 1'b0;
    end
    if (miss_hs && !merged) begin
      st_d[free_id]   = StPend;
      line_d[free_id] = miss_line_i;
      drop_d[free_id] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        st_q[i]   <= StFree;
        line_q[i] <= '0;
      end
      drop_q    <= '0;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      st_q      <= st_d;
      line_q    <= line_d;
      drop_q    <= drop_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Self-checking bench for dcache_mshr_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the entry table.
module tb_dcache_mshr_ctrl;
  localparam int N  = 4;
  localparam int LW = 256;
  localparam int LN = 27;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_valid, miss_ready, miss_merged;
  logic [LN-1:0] miss_line;
  logic [IW-1:0] miss_id;
  logic          mem_req_valid, mem_req_ready;
  logic [LN-1:0] mem_req_line;
  logic [IW-1:0] mem_req_id;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [IW-1:0] mem_rsp_id;
  logic [LW-1:0] mem_rsp_data;
  logic          fill_valid, fill_ready;
  logic [LN-1:0] fill_line;
  logic [LW-1:0] fill_data;
  logic [IW-1:0] fill_id;
  logic          flush;

  always #5 clk = ~clk;

  dcache_mshr_ctrl #(.MSHR_SIZE(N), .PLEN(32), .LINE_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_line_i(miss_line),
    .miss_id_o(miss_id), .miss_merged_o(miss_merged),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_line_o(mem_req_line), .mem_req_id_o(mem_req_id),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
    .mem_rsp_id_i(mem_rsp_id), .mem_rsp_data_i(mem_rsp_data),
    .fill_valid_o(fill_valid), .fill_ready_i(fill_ready), .fill_line_o(fill_line),
    .fill_data_o(fill_data), .fill_id_o(fill_id), .flush_i(flush)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: 0 = free, 1 = pending, 2 = waiting for refill.
  int            m_st   [N];
  logic [LN-1:0] m_line [N];
  bit            m_drop [N];
  int            m_rr;
  bit            m_stall;
  int            m_prev_gnt;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_line[i] = '0; m_drop[i] = 0;
    end
    m_rr = 0; m_stall = 0; m_prev_gnt = 0;
  endtask

  task automatic model_step();
    int  rs, hit, freei, id, gnt;
    bit  rsp_rdy, fvld, retire, can, merged, acc, rv;
    if (!rst_n) begin
      check("rst_miss_ready", miss_ready, 0);
      check("rst_miss_id", miss_id, 0);
      check("rst_merged", miss_merged, 0);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_line", mem_req_line, 0);
      check("rst_req_id", mem_req_id, 0);
      check("rst_rsp_ready", mem_rsp_ready, 0);
      check("rst_fill_valid", fill_valid, 0);
      check("rst_fill_line", fill_line, 0);
      check("rst_fill_data", fill_data, 0);
      check("rst_fill_id", fill_id, 0);
      model_reset();
      return;
    end
    rs = int'(mem_rsp_id);
    if (mem_rsp_valid)
      assert (m_st[rs] == 2) else $error("refill tag %0d points to an idle entry", rs);
    if (m_st[rs] == 2 && !m_drop[rs]) begin
      rsp_rdy = fill_ready; fvld = mem_rsp_valid;
    end else begin
      rsp_rdy = 1; fvld = 0;
    end
    retire = mem_rsp_valid && rsp_rdy && m_st[rs] == 2;

    hit = -1;
    for (int i = 0; i < N; i++) if (m_st[i] != 0 && m_line[i] == miss_line) hit = i;
    freei = -1;
    for (int i = N - 1; i >= 0; i--) if (m_st[i] == 0) freei = i;
`ifdef DCACHE_MSHR_MERGE_EN
    if (hit >= 0) begin
      can = !(retire && rs == hit); id = hit; merged = 1;
    end else begin
      can = freei >= 0; id = freei; merged = 0;
    end
`else
    can = hit < 0 && freei >= 0; id = freei; merged = 0;
`endif
    acc = miss_valid && !flush && can;

    gnt = -1;
    if (m_stall && m_st[m_prev_gnt] == 1) gnt = m_prev_gnt;
    else for (int k = 0; k < N; k++) if (gnt < 0 && m_st[(m_rr + k) % N] == 1) gnt = (m_rr + k) % N;
    rv = gnt >= 0;

    check("miss_ready", miss_ready, acc);
    if (acc) begin
      check("miss_id", miss_id, id);
      check("miss_merged", miss_merged, merged);
    end
    check("req_valid", mem_req_valid, rv);
    if (rv) begin
      check("req_id", mem_req_id, gnt);
      check("req_line", mem_req_line, m_line[gnt]);
    end
    check("rsp_ready", mem_rsp_ready, rsp_rdy);
    check("fill_valid", fill_valid, fvld);
    if (fvld) begin
      check("fill_id", fill_id, rs);
      check("fill_line", fill_line, m_line[rs]);
      check("fill_data", fill_data, mem_rsp_data);
    end

    if (flush)
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 1) m_st[i] = 0;
        if (m_st[i] == 2) m_drop[i] = 1;
      end
    if (rv && mem_req_ready) begin
      m_st[gnt] = 2; m_drop[gnt] = flush; m_rr = (gnt + 1) % N;
    end
    if (retire) begin
      m_st[rs] = 0; m_drop[rs] = 0;
    end
    if (acc && !merged) begin
      m_st[id] = 1; m_line[id] = miss_line; m_drop[id] = 0;
    end
    m_stall    = rv && !mem_req_ready;
    m_prev_gnt = gnt;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    miss_valid = 0; flush = 0; mem_rsp_valid = 0; mem_req_ready = 0; fill_ready = 1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < LW / 32; w++) mem_rsp_data[w*32 +: 32] = $urandom;
  endtask

  // Drive a refill for a random waiting entry, if any exists.
  task automatic pick_refill(input bit enable);
    int ids[$];
    for (int i = 0; i < N; i++) if (m_st[i] == 2) ids.push_back(i);
    rand_data();
    if (enable && ids.size() > 0) begin
      mem_rsp_valid = 1;
      mem_rsp_id    = IW'(ids[$urandom_range(0, ids.size() - 1)]);
    end else begin
      mem_rsp_valid = 0;
      mem_rsp_id    = IW'($urandom_range(0, N - 1));
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      idle(); mem_req_ready = 1;
      pick_refill(1);
      tick();
    end
    idle();
  endtask

  initial begin
    model_reset();
    rst_n = 0; miss_line = '0; mem_rsp_id = '0; mem_rsp_data = '0;
    idle();
    #1;
    tick(); tick();
    rst_n = 1;

    // Basic miss, issue and refill.
    miss_valid = 1; miss_line = 27'h100;
    #2 check("basic_ready", miss_ready, 1); check("basic_id", miss_id, 0);
    tick();
    miss_valid = 0; mem_req_ready = 1;
    #2 check("basic_req_valid", mem_req_valid, 1); check("basic_req_line", mem_req_line, 27'h100);
    check("basic_req_id", mem_req_id, 0);
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_id = 0; rand_data();
    #2 check("basic_fill_valid", fill_valid, 1); check("basic_fill_line", fill_line, 27'h100);
    tick();
    idle(); tick();

    // Capacity: four allocate, fifth stalls until entry 2 retires.
    mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      miss_valid = 1; miss_line = LN'(27'h300 + k);
      #2 check("cap_id", miss_id, k);
      tick();
    end
    miss_line = 27'h304;
    #2 check("cap_full_stall", miss_ready, 0);
    tick();
    mem_rsp_valid = 1; mem_rsp_id = 2; rand_data();
    tick();
    mem_rsp_valid = 0;
    #2 check("cap_reuse_ready", miss_ready, 1); check("cap_reuse_id", miss_id, 2);
    tick();
    drain();

    // Secondary miss to the same line.
    miss_valid = 1; miss_line = 27'h200;
    tick();
`ifdef DCACHE_MSHR_MERGE_EN
    #2 check("merge_ready", miss_ready, 1); check("merge_flag", miss_merged, 1);
    check("merge_id", miss_id, 0);
    tick();
    miss_valid = 0; mem_req_ready = 1;
    tick();
    #2 check("merge_single_req", mem_req_valid, 0);
`else
    #2 check("nomerge_stall", miss_ready, 0);
`endif
    tick();
    drain();

    // Round-robin order and request stability after a fresh reset.
    rst_n = 0; tick(); rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      miss_valid = 1; miss_line = LN'(27'h500 + k); tick();
    end
    miss_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #2 check("rr_stall_id", mem_req_id, 0); check("rr_stall_line", mem_req_line, 27'h500);
      tick();
    end
    mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #2 check("rr_order", mem_req_id, k);
      tick();
    end
    drain();

    // Flush with entries 0,1 waiting and 2,3 pending.
    mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_req_ready = 0;
      miss_valid = 1; miss_line = LN'(27'h600 + k); tick();
    end
    flush = 1; miss_line = 27'h620;
    #2 check("flush_blocks_miss", miss_ready, 0);
    tick();
    flush = 0; miss_line = 27'h610;
    #2 check("flush_freed_req", mem_req_valid, 0); check("flush_realloc_id", miss_id, 2);
    tick();
    miss_valid = 0; fill_ready = 0;
    for (int k = 0; k < 2; k++) begin
      mem_rsp_valid = 1; mem_rsp_id = IW'(k); rand_data();
      #2 check("drop_rsp_ready", mem_rsp_ready, 1); check("drop_fill_valid", fill_valid, 0);
      tick();
    end

    // Fill backpressure holds the refill.
    mem_rsp_valid = 0; mem_req_ready = 1; tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_id = 2; fill_ready = 0;
    for (int k = 0; k < 2; k++) begin
      #2 check("bp_rsp_ready", mem_rsp_ready, 0);
      tick();
    end
    fill_ready = 1; tick();
    idle();

    // Reset mid-operation, then allocation restarts at id 0.
    miss_valid = 1; miss_line = 27'h6ff; tick();
    miss_valid = 0; rst_n = 0; tick(); rst_n = 1;
    miss_valid = 1; miss_line = 27'h700;
    #2 check("post_reset_id", miss_id, 0);
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      miss_valid    = $urandom_range(0, 1) == 1;
      miss_line     = LN'(27'h400 + $urandom_range(0, 5));
      mem_req_ready = $urandom_range(0, 1) == 1;
      fill_ready    = ($urandom_range(0, 3) != 0);
      pick_refill($urandom_range(0, 1) == 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
